pipeline_hazard_ctrl: RTL

//  Parametrised hazard/stall controller for the N-register in-order pipeline, succeeding the fixed 4-register ihit/dhit unit.

---
 rtl/pipeline_hazard_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard/stall controller for an N-register in-order pipeline. Produces the
// per-register load enables and synchronous flushes, the PC load enable and
// the PC source select. It handles:
//   * data-memory wait: the whole pipe freezes until dhit,
//   * taken-branch redirect: registers younger than RESOLVE_IDX are flushed,
//   * load-use bubble: ID holds and a bubble is inserted behind the load,
//   * fetch miss: a bubble is inserted behind the stalled fetch,
//   * jump redirect from ID,
//   * a sticky halt state that is left only through RST.
//
// Optional build macro: HAZARD_PERF_EN adds the stall_cycles / flush_events
// performance counters.
//
// Parameters
//   NUM_STAGES   number of pipeline registers (index 0 = IF/ID), 3..8
//   REG_AW       register-file address width
//   RESOLVE_IDX  stage index that produces branch_taken, 1..NUM_STAGES-1
//
// Ports
//   CLK, RST                  clock (rising edge), synchronous active-high reset
//   ihit                      instruction fetch complete this cycle
//   dmem_req, dhit            MEM-stage access outstanding / access complete
//   id_rs, id_rt              ID-stage source registers
//   id_uses_rs, id_uses_rt    ID instruction actually reads rs / rt
//   ex_memread, ex_rd         EX-stage load flag and destination register
//   branch_taken              taken branch resolved at stage RESOLVE_IDX
//   jump_id                   jump decoded in ID
//   halt_wb                   halt instruction in the last stage
//   enable[NUM_STAGES]        per-register load enable
//   flush[NUM_STAGES]         per-register synchronous clear
//   enable_pc                 PC load enable
//   pc_sel[2]                 0 PC+4, 1 branch target, 2 jump target
//   halted                    core halted
//   stall_cycles[32]          (HAZARD_PERF_EN) DMEM wait, load-use, fetch-miss cycles
//   flush_events[32]          (HAZARD_PERF_EN) branch and jump redirects
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int NUM_STAGES  = 4,
    parameter int REG_AW      = 5,
    parameter int RESOLVE_IDX = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ihit,
    input  logic                  dmem_req,
    input  logic                  dhit,
    input  logic [REG_AW-1:0]     id_rs,
    input  logic [REG_AW-1:0]     id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_memread,
    input  logic [REG_AW-1:0]     ex_rd,
    input  logic                  branch_taken,
    input  logic                  jump_id,
    input  logic                  halt_wb,
    output logic [NUM_STAGES-1:0] enable,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  enable_pc,
    output logic [1:0]            pc_sel,
    output logic                  halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_events
`endif
);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_DMEM_WAIT = 2'd1,
        S_HALTED    = 2'd2
    } state_t;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    // Registers older than the branch-resolving stage keep their contents.
    localparam logic [NUM_STAGES-1:0] BR_MASK = ~({NUM_STAGES{1'b1}} << RESOLVE_IDX);

    state_t state_q, state_d;

    logic load_use;
    logic frozen;

`ifdef HAZARD_PERF_EN
    logic        stall_evt;
    logic        redirect_evt;
    logic [31:0] stall_q, stall_d;
    logic [31:0] fev_q, fev_d;
`endif

    // A zero destination never creates a dependency.
    assign load_use = ex_memread && (ex_rd != '0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd)));

    // Once waiting, only dhit releases the pipe; dmem_req is not re-examined.
    assign frozen = !dhit && (dmem_req || (state_q == S_DMEM_WAIT));

    always_comb begin
        state_d   = state_q;
        enable    = '0;
        flush     = '0;
        enable_pc = 1'b0;
        pc_sel    = PC_SEQ;
        halted    = 1'b0;
`ifdef HAZARD_PERF_EN
        stall_evt    = 1'b0;
        redirect_evt = 1'b0;
`endif
        if (RST) begin
            flush   = '1;
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_HALTED: begin
                    halted = 1'b1;
                end
                S_RUN, S_DMEM_WAIT: begin
                    if (frozen) begin
                        state_d = S_DMEM_WAIT;
`ifdef HAZARD_PERF_EN
                        stall_evt = 1'b1;
`endif
                    end else begin
                        // Advancing cycle (includes the dhit cycle leaving DMEM_WAIT).
                        state_d   = halt_wb ? S_HALTED : S_RUN;
                        enable    = '1;
                        enable_pc = ihit;
                        if (branch_taken) begin
                            // Any pending fetch is abandoned, so the PC loads regardless of ihit.
                            flush     = BR_MASK;
                            pc_sel    = PC_BRANCH;
                            enable_pc = 1'b1;
`ifdef HAZARD_PERF_EN
                            redirect_evt = 1'b1;
`endif
                        end else if (load_use) begin
                            // Hold ID, let the load move on and bubble the slot behind it.
                            enable[0] = 1'b0;
                            flush[1]  = 1'b1;
                            enable_pc = 1'b0;
`ifdef HAZARD_PERF_EN
                            stall_evt = 1'b1;
`endif
                        end else if (!ihit) begin
                            flush[0]  = 1'b1;
                            enable_pc = 1'b0;
`ifdef HAZARD_PERF_EN
                            stall_evt = 1'b1;
`endif
                        end else if (jump_id) begin
                            flush[0]  = 1'b1;
                            pc_sel    = PC_JUMP;
                            enable_pc = 1'b1;
`ifdef HAZARD_PERF_EN
                            redirect_evt = 1'b1;
`endif
                        end
                    end
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef HAZARD_PERF_EN
    // Event flags are never set in HALTED, so the counters hold there.
    always_comb begin
        stall_d = stall_q + {31'd0, stall_evt};
        fev_d   = fev_q + {31'd0, redirect_evt};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
            fev_q   <= '0;
        end else begin
            stall_q <= stall_d;
            fev_q   <= fev_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = fev_q;
`endif

endmodule
